// File: rtl/score_display_driver_pkg.sv
// Shared encodings and glyph table for the score display driver.
package score_display_driver_pkg;

  // BCD converter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } bcd_state_e;

  // view select encoding
  localparam logic [1:0] VIEW_POINTS  = 2'd0;
  localparam logic [1:0] VIEW_POINTS2 = 2'd1;
  localparam logic [1:0] VIEW_HS      = 2'd2;
  localparam logic [1:0] VIEW_POINTS3 = 2'd3;

  // letter encoding; 5..7 fall through to blank
  localparam logic [2:0] LETTER_NONE = 3'd0;
  localparam logic [2:0] LETTER_L    = 3'd1;
  localparam logic [2:0] LETTER_U    = 3'd2;
  localparam logic [2:0] LETTER_C    = 3'd3;
  localparam logic [2:0] LETTER_D    = 3'd4;

  // active-low segments, bit order gfedcba
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_P     = 7'b0001100;
  localparam logic [6:0] GLYPH_B     = 7'b0000011;
  localparam logic [6:0] GLYPH_H     = 7'b0001001;
  localparam logic [6:0] GLYPH_L     = 7'b1000111;
  localparam logic [6:0] GLYPH_U     = 7'b1000001;
  localparam logic [6:0] GLYPH_C     = 7'b1000110;
  localparam logic [6:0] GLYPH_D     = 7'b0100001;

  localparam int unsigned BCD_BITS = 7;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    digit_glyph = 7'h40;
      4'd1:    digit_glyph = 7'h79;
      4'd2:    digit_glyph = 7'h24;
      4'd3:    digit_glyph = 7'h30;
      4'd4:    digit_glyph = 7'h19;
      4'd5:    digit_glyph = 7'h12;
      4'd6:    digit_glyph = 7'h02;
      4'd7:    digit_glyph = 7'h78;
      4'd8:    digit_glyph = 7'h00;
      4'd9:    digit_glyph = 7'h10;
      default: digit_glyph = GLYPH_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/score_display_driver_if.sv
// Score inputs and display outputs bundled between the selector and the driver.
interface score_display_driver_if;
  logic [6:0] points;
  logic [6:0] points2;
  logic [6:0] hs;
  logic [2:0] letter;
  logic       flash;
  logic [1:0] view;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  modport master (output points, points2, hs, letter, flash, view,
                  input  seg, an, dp);
  modport slave  (input  points, points2, hs, letter, flash, view,
                  output seg, an, dp);
endinterface

// File: rtl/score_display_driver_bin2bcd.sv
// Sequential shift-add-3 binary to BCD, one bit per clock, for values 0..99.
module bin2bcd_seq
  import score_display_driver_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       busy
);

  bcd_state_e  state_q, state_d;
  logic [14:0] sh_q, sh_d;
  logic [14:0] adj;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  last_q, last_d;
  logic [3:0]  tens_q, tens_d;
  logic [3:0]  units_q, units_d;

  function automatic logic [3:0] add3(input logic [3:0] n);
    add3 = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // state and datapath registers; reset also discards any conversion in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      last_q  <= 7'h7F;
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  // next state: only IDLE looks at the input, so changes mid-conversion wait
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bin != last_q) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == 3'd0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // datapath: load, adjust-then-shift, latch nibbles
  always_comb begin
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    tens_d  = tens_q;
    units_d = units_q;
    adj     = {add3(sh_q[14:11]), add3(sh_q[10:7]), sh_q[6:0]};
    case (state_q)
      ST_LOAD: begin
        sh_d   = {8'b0, bin};
        cnt_d  = 3'(BCD_BITS - 1);
        last_d = bin;
      end
      ST_SHIFT: begin
        sh_d  = {adj[13:0], 1'b0};
        cnt_d = cnt_q - 3'd1;
      end
      ST_DONE: begin
        tens_d  = sh_q[14:11];
        units_d = sh_q[10:7];
      end
      default: ;
    endcase
  end

  assign tens  = tens_q;
  assign units = units_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: rtl/score_display_driver.sv
// Basys3 4-digit display driver: value select, BCD, digit scan and game-over blink.
module score_display_driver
  import score_display_driver_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  score_display_driver_if.slave bus
);

  localparam int unsigned RW = $clog2(REFRESH_DIV);
  localparam int unsigned BW = $clog2(BLINK_DIV);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [RW-1:0] REF_ONE  = RW'(1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [BW-1:0] BLK_ONE  = BW'(1);

  logic [6:0]    sel, sat;
  logic [3:0]    tens, units;
  logic          bcd_busy;
  logic [6:0]    slot_glyph;
  logic          ref_wrap, blk_wrap;

  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_sel_q, an_sel_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [BW-1:0] blk_cnt_q, blk_cnt_d;
  logic          phase_q, phase_d;

  // pick the score for the current view and clamp to two digits
  always_comb begin
    case (bus.view)
      VIEW_POINTS2: sel = bus.points2;
      VIEW_HS:      sel = bus.hs;
      default:      sel = bus.points;
    endcase
    sat = (sel > 7'd99) ? 7'd99 : sel;
  end

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .bin   (sat),
    .tens  (tens),
    .units (units),
    .busy  (bcd_busy)
  );

  // glyph for the digit slot that is about to be lit
  always_comb begin
    slot_glyph = GLYPH_BLANK;
    case (idx_q)
      2'd0: slot_glyph = digit_glyph(units);
      2'd1: slot_glyph = (tens == 4'd0) ? GLYPH_BLANK : digit_glyph(tens);
      2'd2: begin
        case (bus.view)
          VIEW_POINTS2: slot_glyph = GLYPH_B;
          VIEW_HS:      slot_glyph = GLYPH_H;
          default:      slot_glyph = GLYPH_P;
        endcase
      end
      default: begin
        case (bus.letter)
          LETTER_L: slot_glyph = GLYPH_L;
          LETTER_U: slot_glyph = GLYPH_U;
          LETTER_C: slot_glyph = GLYPH_C;
          LETTER_D: slot_glyph = GLYPH_D;
          default:  slot_glyph = GLYPH_BLANK;
        endcase
      end
    endcase
  end

  // scan and blink next-state; blanking overrides the anode select every cycle
  always_comb begin
    ref_wrap  = (ref_cnt_q == REF_LAST);
    blk_wrap  = bus.flash && (blk_cnt_q == BLK_LAST);
    ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + REF_ONE;
    idx_d     = ref_wrap ? idx_q + 2'd1 : idx_q;
    an_sel_d  = ref_wrap ? ~(4'b0001 << idx_q) : an_sel_q;
    seg_d     = ref_wrap ? slot_glyph : seg_q;
    if (!bus.flash) begin
      blk_cnt_d = '0;
      phase_d   = 1'b0;
    end else begin
      blk_cnt_d = blk_wrap ? '0 : blk_cnt_q + BLK_ONE;
      phase_d   = blk_wrap ? ~phase_q : phase_q;
    end
    an_d = phase_d ? 4'b1111 : an_sel_d;
  end

  // scan, blink and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_q <= '0;
      idx_q     <= '0;
      an_sel_q  <= 4'b1111;
      an_q      <= 4'b1111;
      seg_q     <= GLYPH_BLANK;
      blk_cnt_q <= '0;
      phase_q   <= 1'b0;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      idx_q     <= idx_d;
      an_sel_q  <= an_sel_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      blk_cnt_q <= blk_cnt_d;
      phase_q   <= phase_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_score_display_driver.sv
// Scoreboard bench for score_display_driver with REFRESH_DIV=4, BLINK_DIV=16.
module tb_score_display_driver;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    int         edge_no;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];

  score_display_driver_if bus();

  score_display_driver #(.REFRESH_DIV(4), .BLINK_DIV(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // edges since reset release
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] m_digit(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  function automatic logic [6:0] m_slot(input int idx);
    int s;
    case (bus.view)
      2'd1:    s = bus.points2;
      2'd2:    s = bus.hs;
      default: s = bus.points;
    endcase
    if (s > 99) s = 99;
    case (idx)
      0: return m_digit(s % 10);
      1: return (s / 10 == 0) ? 7'h7F : m_digit(s / 10);
      2: return (bus.view == 2'd1) ? 7'b0000011 :
                (bus.view == 2'd2) ? 7'b0001001 : 7'b0001100;
      default: begin
        case (bus.letter)
          3'd1:    return 7'b1000111;
          3'd2:    return 7'b1000001;
          3'd3:    return 7'b1000110;
          3'd4:    return 7'b0100001;
          default: return 7'h7F;
        endcase
      end
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // align so the next edge starts a digit slot, then queue the next four slots
  task automatic expect_slots();
    exp_t e;
    int   m;
    for (int k = 0; k < 4 && (cyc % 4) != 3; k++) step(1);
    for (int j = 0; j < 4; j++) begin
      m         = cyc + 1 + 4 * j;
      e.edge_no = m;
      e.an      = ~(4'b0001 << ((m / 4 - 1) % 4));
      e.seg     = m_slot((m / 4 - 1) % 4);
      q.push_back(e);
    end
    step(16);
  endtask

  // monitor: each slot start presents a new digit; compare against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (!rst && cyc >= 4 && (cyc % 4) == 0 && q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("slot_edge%0d_an", e.edge_no), bus.an, e.an);
      chk($sformatf("slot_edge%0d_seg", e.edge_no), bus.seg, e.seg);
      chk("dp", bus.dp, 1);
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.points = 0; bus.points2 = 0; bus.hs = 0;
    bus.letter = 0; bus.flash = 0; bus.view = 0;

    // reset
    step(3);
    chk("rst_an", bus.an, 4'hF);
    chk("rst_seg", bus.seg, 7'h7F);
    chk("rst_dp", bus.dp, 1);
    rst = 1'b0;

    // scan order after release
    for (int k = 1; k <= 16; k++) begin
      step(1);
      chk($sformatf("scan_k%0d", k), bus.an,
          (k < 4) ? 4'hF : int'(~(4'b0001 << ((k / 4 - 1) % 4)) & 4'hF));
    end

    // 57: conversion latency of 10 edges
    bus.points = 57;
    step(9);
    chk("lat9_units", u_dut.u_bcd.units, 0);
    step(1);
    chk("lat10_tens", u_dut.u_bcd.tens, 5);
    chk("lat10_units", u_dut.u_bcd.units, 7);
    expect_slots();

    // directed patterns: saturation, tens blank, letters
    bus.view = 2; bus.hs = 120;    step(24); expect_slots();
    bus.view = 1; bus.points2 = 4; step(24); expect_slots();
    bus.view = 0; bus.letter = 3;  step(24); expect_slots();
    bus.letter = 6;                step(24); expect_slots();

    // input change during the 3rd shift is deferred
    bus.points = 10; step(24);
    bus.points = 57; step(4);
    bus.points = 58; step(15);
    chk("defer19_tens", u_dut.u_bcd.tens, 5);
    chk("defer19_units", u_dut.u_bcd.units, 7);
    step(1);
    chk("defer20_tens", u_dut.u_bcd.tens, 5);
    chk("defer20_units", u_dut.u_bcd.units, 8);
    expect_slots();

    // reset mid-shift
    bus.points = 42; step(4);
    rst = 1'b1; step(1);
    chk("rstmid_tens", u_dut.u_bcd.tens, 0);
    chk("rstmid_units", u_dut.u_bcd.units, 0);
    chk("rstmid_an", bus.an, 4'hF);
    chk("rstmid_seg", bus.seg, 7'h7F);
    rst = 1'b0;
    step(24); expect_slots();

    // blink: blanked for edges 16..31 and 48..56, lit again 1 edge after flash drops
    bus.flash = 1'b1;
    for (int k = 1; k <= 57; k++) begin
      if (k == 57) bus.flash = 1'b0;
      step(1);
      chk($sformatf("blink_k%0d", k), (bus.an == 4'hF),
          (k <= 56) && ((k / 16) % 2 == 1));
    end
    step(8); expect_slots();

    // randomized
    for (int r = 0; r < 12; r++) begin
      bus.points  = 7'($urandom_range(0, 127));
      bus.points2 = 7'($urandom_range(0, 127));
      bus.hs      = 7'($urandom_range(0, 127));
      bus.letter  = 3'($urandom_range(0, 7));
      bus.view    = 2'($urandom_range(0, 3));
      step(24);
      expect_slots();
    end

    n = q.size();
    chk("queue_drained", n, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
